memory_stage: RTL

// - Y86-64 SEQ memory stage; sits directly downstream of execute and consumes valE/valA/icode.
// - Holds a byte-addressed, little-endian data memory.
// - Performs the 8-byte load/store required by rmmovq, mrmovq, pushq, popq, call and ret.
// - Returns valM plus an address-error flag; the start/done handshake allows multi-cycle stepping.

---
 rtl/memory_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: byte-addressed little-endian data memory with a start/done handshake.
// Optional build macro DMEM_ZERO_ON_RESET_EN clears every memory byte on rst.
module memory_stage #(
   parameter int MEM_BYTES = 1024,
   parameter int DATA_W    = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        icode,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valA,
   input  logic [DATA_W-1:0] valP,
   output logic [DATA_W-1:0] valM,
   output logic              busy,
   output logic              done,
   output logic              dmem_error
);

   localparam int AW = $clog2(MEM_BYTES);
   localparam logic [DATA_W-1:0] LAST_OK = DATA_W'(MEM_BYTES - 8);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_wr;
   logic              r_rd;
   logic [DATA_W-1:0] r_valM;
   logic              r_err;
   logic [7:0]        r_mem [MEM_BYTES];

   logic              w_wr;
   logic              w_rd;
   logic [DATA_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_in_range;
   logic              w_do_write;
   logic [AW-1:0]     w_base;
   logic [DATA_W-1:0] w_rdata;

   // Access map: which operand is the address and which is the store data.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_wr    = 1'b0;
      w_rd    = 1'b0;
      w_addr  = valE;
      w_wdata = valA;
      case (icode)
         I_RMMOVQ, I_PUSHQ: w_wr = 1'b1;
         I_CALL: begin
            w_wr    = 1'b1;
            w_wdata = valP;
         end
         I_MRMOVQ: w_rd = 1'b1;
         I_POPQ, I_RET: begin
            w_rd   = 1'b1;
            w_addr = valA;
         end
         default: ;
      endcase
   end

   // Full-width unsigned compare so huge or negative addresses cannot wrap into range.
   assign w_in_range = (r_addr <= LAST_OK);
   assign w_base     = r_addr[AW-1:0];
   assign w_do_write = (r_state == S_ACCESS) && r_wr && w_in_range;

   always_comb begin
      w_rdata = '0;
      for (int k = 0; k < 8; k++) begin
         w_rdata[8*k +: 8] = r_mem[w_base + AW'(k)];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_valM  <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_wr    <= w_wr;
                  r_rd    <= w_rd;
                  r_err   <= 1'b0;
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if ((r_wr || r_rd) && !w_in_range) begin
                  r_err <= 1'b1;
               end else if (r_rd) begin
                  r_valM <= w_rdata;
               end
               r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef DMEM_ZERO_ON_RESET_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_BYTES; i++) begin
            r_mem[i] <= 8'h00;
         end
      end else if (w_do_write) begin
         for (int k = 0; k < 8; k++) begin
            r_mem[w_base + AW'(k)] <= r_wdata[8*k +: 8];
         end
      end
   end
`else
   // NOTE: the array is deliberately not reset so it maps onto plain RAM; rst only blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && w_do_write) begin
         for (int k = 0; k < 8; k++) begin
            r_mem[w_base + AW'(k)] <= r_wdata[8*k +: 8];
         end
      end
   end
`endif

   assign valM       = r_valM;
   assign busy       = (r_state == S_ACCESS);
   assign done       = (r_state == S_DONE);
   assign dmem_error = r_err;

endmodule
